// File: rtl/layer_tile_scheduler_pkg.sv
// Shared definitions for the layer tile scheduler: FSM state encoding and
// default widths / watchdog limit used by the top and the watchdog counter.
package layer_tile_scheduler_pkg;

    localparam int K_W_DEF        = 32;
    localparam int TILE_W_DEF     = 16;
    localparam int WDT_CYCLES_DEF = 65536;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_FINISH    = 3'd3,
        S_ABORT     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/layer_tile_scheduler_watchdog.sv
// sched_watchdog: clear/enable/expire cycle counter. Held at zero while
// clear is high, counts while enable is high, and flags expiry on the
// WDT_CYCLES-th enabled cycle. Only instantiated when
// LAYER_SCHED_WATCHDOG_EN is defined.
module sched_watchdog
    import layer_tile_scheduler_pkg::*;
#(
    parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(WDT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Expiry is seen on the edge that completes the WDT_CYCLES-th waiting cycle.
    assign expired = enable && (count == LAST);

    // Cycle counter: cleared outside the wait window, saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/layer_tile_scheduler.sv
// layer_tile_scheduler: accepts one layer command (K dimension, tile count)
// and drives one global_controller ap_start/ap_done run per tile, reporting
// progress, completion and sticky errors to the host side.
// Optional per-tile watchdog: define LAYER_SCHED_WATCHDOG_EN.
module layer_tile_scheduler
    import layer_tile_scheduler_pkg::*;
#(
    parameter int K_W        = K_W_DEF,
    parameter int TILE_W     = TILE_W_DEF,
    parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [K_W-1:0]    cmd_k_dim,
    input  logic [TILE_W-1:0] cmd_num_tiles,
    input  logic              sw_abort,
    output logic              ap_start,
    output logic [K_W-1:0]    cfg_k_dim,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic              busy,
    output logic              layer_done,
    output logic [TILE_W-1:0] tiles_completed,
    output logic              err_zero_k,
    output logic              err_timeout
);

    sched_state_t      state;
    logic [TILE_W-1:0] tile_limit;
    logic [TILE_W-1:0] next_tiles;
    logic              last_tile;
    logic              accept;
    logic              wdt_expired;
    logic              timeout_fire;

    assign accept       = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign next_tiles   = tiles_completed + 1'b1;
    assign last_tile    = (next_tiles == tile_limit);
    // Completion and abort take precedence over a coincident watchdog expiry.
    assign timeout_fire = (state == S_WAIT_DONE) && !sw_abort && !ap_done && wdt_expired;

`ifdef LAYER_SCHED_WATCHDOG_EN
    sched_watchdog #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != S_WAIT_DONE),
        .enable  (state == S_WAIT_DONE),
        .expired (wdt_expired)
    );

    // Sticky timeout flag, cleared only when a new command is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (accept) begin
            err_timeout <= 1'b0;
        end else if (timeout_fire) begin
            err_timeout <= 1'b1;
        end
    end
`else
    logic unused_wdt;
    assign unused_wdt  = ^WDT_CYCLES;
    assign wdt_expired = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Layer sequencing FSM; every host/controller-facing output is a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            ap_start        <= 1'b0;
            cfg_k_dim       <= '0;
            tile_limit      <= '0;
            tiles_completed <= '0;
            layer_done      <= 1'b0;
            err_zero_k      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge values
            // and a later assignment in the same branch overrides the default.
            layer_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready       <= 1'b0;
                        busy            <= 1'b1;
                        cfg_k_dim       <= cmd_k_dim;
                        tile_limit      <= cmd_num_tiles;
                        tiles_completed <= '0;
                        err_zero_k      <= (cmd_k_dim == '0);
                        if ((cmd_k_dim == '0) || (cmd_num_tiles == '0)) begin
                            state <= S_FINISH;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (sw_abort) begin
                        ap_start <= 1'b0;
                        state    <= S_ABORT;
                    end else if (!ap_start) begin
                        // Only start a controller that reports idle.
                        if (ap_idle) begin
                            ap_start <= 1'b1;
                        end
                    end else if (ap_done) begin
                        // A run that finished before we saw idle drop.
                        ap_start        <= 1'b0;
                        tiles_completed <= next_tiles;
                        state           <= last_tile ? S_FINISH : S_ISSUE;
                    end else if (!ap_idle) begin
                        ap_start <= 1'b0;
                        state    <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (sw_abort) begin
                        state <= S_ABORT;
                    end else if (ap_done) begin
                        tiles_completed <= next_tiles;
                        state           <= last_tile ? S_FINISH : S_ISSUE;
                    end else if (timeout_fire) begin
                        state <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    // Let the controller drain before reporting the layer as ended.
                    if (ap_idle) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    layer_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    ap_start <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Testbench for layer_tile_scheduler: a behavioural global_controller
// responder, a scoreboard of per-layer expectations pushed at command time,
// and a negedge monitor that pops and compares on every layer_done.
// Works with or without LAYER_SCHED_WATCHDOG_EN.
module tb_layer_tile_scheduler;

    localparam int K_W    = 32;
    localparam int TILE_W = 16;
    localparam int WDT    = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [K_W-1:0]    cmd_k_dim = '0;
    logic [TILE_W-1:0] cmd_num_tiles = '0;
    logic              sw_abort = 1'b0;
    logic              ap_start;
    logic [K_W-1:0]    cfg_k_dim;
    logic              ap_done = 1'b0;
    logic              ap_idle = 1'b1;
    logic              busy;
    logic              layer_done;
    logic [TILE_W-1:0] tiles_completed;
    logic              err_zero_k;
    logic              err_timeout;

    layer_tile_scheduler #(
        .K_W        (K_W),
        .TILE_W     (TILE_W),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_k_dim       (cmd_k_dim),
        .cmd_num_tiles   (cmd_num_tiles),
        .sw_abort        (sw_abort),
        .ap_start        (ap_start),
        .cfg_k_dim       (cfg_k_dim),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .busy            (busy),
        .layer_done      (layer_done),
        .tiles_completed (tiles_completed),
        .err_zero_k      (err_zero_k),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected outcome of one layer, derived from the command and the plan.
    typedef struct {
        logic [31:0] k;
        int          tiles;
        int          starts;
        bit          zero_k;
        bit          timeout;
        int          lat_start;
        int          lat_done;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t predict(input logic [31:0] k, input int n,
                                     input int abort_tile, input bit timeout);
        exp_t e;
        e.k         = k;
        e.zero_k    = (k == 0);
        e.timeout   = timeout;
        e.lat_start = -1;
        e.lat_done  = -1;
        if (k == 0 || n == 0) begin
            e.tiles    = 0;
            e.starts   = 0;
            e.lat_done = 2;
        end else begin
            e.lat_start = 2;
            if (timeout) begin
                e.tiles  = 0;
                e.starts = 1;
            end else if (abort_tile > 0) begin
                e.tiles  = abort_tile - 1;
                e.starts = abort_tile;
            end else begin
                e.tiles  = n;
                e.starts = n;
            end
        end
        return e;
    endfunction

    // ---------------- controller responder ----------------
    int model_run         = 20;
    int model_delay       = 0;
    bit model_hang        = 0;
    int model_hang_cycles = 150;

    initial begin
        int phase = 0;
        int mcnt  = 0;
        bit mhang = 0;
        forever begin
            @(posedge clk);
            #1;
            ap_done = 1'b0;
            if (!rst_n) begin
                phase   = 0;
                ap_idle = 1'b1;
            end else begin
                case (phase)
                    0: if (ap_start) begin
                        mhang = model_hang;
                        if (model_delay == 0) begin
                            ap_idle = 1'b0;
                            phase   = 2;
                            mcnt    = mhang ? model_hang_cycles : model_run;
                        end else begin
                            phase = 1;
                            mcnt  = model_delay;
                        end
                    end
                    1: if (!ap_start) begin
                        phase = 0;
                    end else begin
                        mcnt--;
                        if (mcnt == 0) begin
                            ap_idle = 1'b0;
                            phase   = 2;
                            mcnt    = mhang ? model_hang_cycles : model_run;
                        end
                    end
                    default: begin
                        mcnt--;
                        if (mcnt == 0) begin
                            ap_idle = 1'b1;
                            ap_done = !mhang;
                            phase   = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int cyc       = 0;
    int acc_cyc   = 0;
    int start_cnt = 0;

    initial begin
        bit   prev_start = 0;
        bit   prev_idle  = 1;
        bit   prev_ldone = 0;
        int   prev_tiles = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_start = 0;
                prev_idle  = 1;
                prev_ldone = 0;
                prev_tiles = 0;
                start_cnt  = 0;
                continue;
            end
            if (ap_start && !prev_start) begin
                start_cnt++;
                check("start_needs_idle", prev_idle, 1);
                if (exp_q.size() > 0) begin
                    check("cfg_k_at_start", cfg_k_dim, exp_q[0].k);
                    if (start_cnt == 1 && exp_q[0].lat_start >= 0)
                        check("first_start_latency", cyc - acc_cyc, exp_q[0].lat_start);
                end
            end
            if (prev_start && !prev_idle)
                check("start_drop_after_accept", ap_start, 0);
            if (int'(tiles_completed) != prev_tiles && tiles_completed != 0)
                check("tiles_step", tiles_completed, prev_tiles + 1);
            if (prev_ldone) begin
                check("done_single_pulse", layer_done, 0);
                check("ready_after_done", cmd_ready, 1);
            end
            if (layer_done) begin
                check("done_has_expectation", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tiles_completed", tiles_completed, e.tiles);
                    check("cfg_k_dim", cfg_k_dim, e.k);
                    check("err_zero_k", err_zero_k, e.zero_k);
                    check("err_timeout", err_timeout, e.timeout);
                    check("start_count", start_cnt, e.starts);
                    check("busy_at_done", busy, 0);
                    check("ready_at_done", cmd_ready, 0);
                    if (e.lat_done >= 0)
                        check("done_latency", cyc - acc_cyc, e.lat_done);
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc   = cyc;
                start_cnt = 0;
            end
            prev_start = ap_start;
            prev_idle  = ap_idle;
            prev_ldone = layer_done;
            prev_tiles = int'(tiles_completed);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_cmd(input logic [31:0] k, input int n);
        int waited = 0;
        @(posedge clk);
        #1;
        cmd_valid     = 1'b1;
        cmd_k_dim     = k;
        cmd_num_tiles = TILE_W'(n);
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            waited++;
            if (waited > 5000) begin
                check("cmd_accept_bound", cmd_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] k, input int n, input int abort_tile, input bit timeout);
        exp_q.push_back(predict(k, n, abort_tile, timeout));
        send_cmd(k, n);
    endtask

    task automatic abort_in_tile(input int t);
        int waited = 0;
        forever begin
            @(negedge clk);
            if (start_cnt == t && !ap_idle) break;
            waited++;
            if (waited > 5000) begin
                check("abort_wait_bound", start_cnt, t);
                break;
            end
        end
        @(posedge clk);
        #1;
        sw_abort = 1'b1;
        @(posedge clk);
        #1;
        sw_abort = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || busy || !cmd_ready) && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        check("drain_bound", exp_q.size(), 0);
    endtask

    task automatic wait_start_fall(output bit ok);
        int waited = 0;
        ok = 1;
        while (!ap_start && waited < 2000) begin @(negedge clk); waited++; end
        while (ap_start && waited < 4000) begin @(negedge clk); waited++; end
        if (waited >= 4000) begin
            ok = 0;
            check("start_fall_bound", ap_start, 0);
        end
    endtask

    initial begin
        int n, t, k, cnt;
        bit ok;
        #1 rst_n = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ap_start", ap_start, 0);
        check("rst_busy", busy, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_tiles", tiles_completed, 0);
        check("rst_cfg_k", cfg_k_dim, 0);
        check("rst_err_zero_k", err_zero_k, 0);
        check("rst_err_timeout", err_timeout, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal three-tile layer.
        issue(32'd32, 3, 0, 0);
        drain();
        // Zero tiles, then zero K (no starts either way).
        issue(32'd32, 0, 0, 0);
        issue(32'd0, 4, 0, 0);
        drain();
        // Slow acceptance by the controller.
        model_delay = 5;
        issue(32'd7, 2, 0, 0);
        drain();
        model_delay = 0;
        // Second command held while busy.
        issue(32'd11, 3, 0, 0);
        issue(32'd99, 1, 0, 0);
        drain();
        // Abort during tile 2 of 4.
        issue(32'd8, 4, 2, 0);
        abort_in_tile(2);
        drain();

        // Randomized layers, some aborted, some zero-sized.
        for (int i = 0; i < 15; i++) begin
            model_run   = int'($urandom_range(4, 25));
            model_delay = int'($urandom_range(0, 3));
            n = int'($urandom_range(0, 5));
            k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom);
            t = (n > 0 && k != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
            issue(k, n, t, 0);
            if (t > 0) abort_in_tile(t);
        end
        drain();
        model_run   = 20;
        model_delay = 0;

`ifdef LAYER_SCHED_WATCHDOG_EN
        // Controller never completes: watchdog ends the layer.
        model_hang        = 1;
        model_hang_cycles = 150;
        issue(32'd5, 2, 0, 1);
        wait_start_fall(ok);
        cnt = 0;
        while (ok && !err_timeout && cnt < 1000) begin @(negedge clk); cnt++; end
        check("timeout_cycles", cnt, WDT);
        drain();
        model_hang = 0;
`endif

        // Controller hangs; layer stays busy until an asynchronous reset.
        model_hang        = 1;
        model_hang_cycles = 100000;
        send_cmd(32'd77, 3);
        wait_start_fall(ok);
`ifdef LAYER_SCHED_WATCHDOG_EN
        repeat (30) @(negedge clk);
`else
        repeat (300) @(negedge clk);
`endif
        check("hang_busy", busy, 1);
        check("hang_no_timeout", err_timeout, 0);
        check("hang_tiles", tiles_completed, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ap_start", ap_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_cfg_k", cfg_k_dim, 0);
        model_hang = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // Clean layer after reset.
        issue(32'd3, 1, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/layer_tile_scheduler.md
Name: layer_tile_scheduler

Overview:
- Host-side initiator for the global_controller ap_start/ap_done/ap_idle handshake.
- Accepts one layer command (K dimension, tile count) over a valid/ready port and issues one controller run per tile, waiting for ap_done between runs.
- Reports layer completion, progress and errors to the CSR/host layer.
- Sits between the command/CSR block and global_controller.

Parameters:
- K_W, 32, width of cfg_k_dim / cmd_k_dim
- TILE_W, 16, width of tile count and progress counter
- WDT_CYCLES, 65536, watchdog limit in cycles per tile (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  layer command valid
- cmd_ready  out  1  scheduler can accept a command
- cmd_k_dim  in  K_W  K dimension for every tile of the layer
- cmd_num_tiles  in  TILE_W  number of tiles (controller runs) in the layer
- sw_abort  in  1  abort the current layer (level, sampled each cycle)
- ap_start  out  1  start request to global_controller
- cfg_k_dim  out  K_W  latched K dimension driven to global_controller
- ap_done  in  1  controller completion pulse
- ap_idle  in  1  controller idle status
- busy  out  1  layer in progress
- layer_done  out  1  one-cycle pulse at layer end (normal, abort or error)
- tiles_completed  out  TILE_W  tiles finished in the current or last layer
- err_zero_k  out  1  sticky: a command had cmd_k_dim==0
- err_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset values: every output is 0, except cmd_ready=1. The FSM resets to S_IDLE.
- FSM states: S_IDLE, S_ISSUE, S_WAIT_DONE, S_FINISH, S_ABORT. All outputs are registered.
- S_IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid & cmd_ready: latch k_dim into cfg_k_dim and num_tiles into the tile limit, and clear tiles_completed.
  - Next state is S_FINISH if num_tiles==0 or k_dim==0; otherwise S_ISSUE.
  - k_dim==0 also sets err_zero_k. In this case no ap_start is issued.
- S_ISSUE:
  - ap_start rises on the first cycle ap_idle==1 is sampled in this state, then stays high.
  - When ap_idle==0 is sampled with ap_start high, the start is accepted: ap_start drops on the next edge and the FSM goes to S_WAIT_DONE.
  - ap_done==1 sampled while ap_start is high counts as both acceptance and completion.
- S_WAIT_DONE:
  - On ap_done==1, tiles_completed increments.
  - If the new count equals the tile limit, go to S_FINISH; otherwise go to S_ISSUE.
  - The next ap_start waits again for ap_idle==1, so back-to-back starts never overlap a DONE state.
- S_FINISH: layer_done=1 for exactly one cycle, busy drops, then S_IDLE. cmd_ready returns to 1 the cycle after layer_done.
- busy=1 and cmd_ready=0 in every state except S_IDLE. A command presented while busy is held and not consumed.
- Latency: with ap_idle=1, cmd accept at edge N gives S_ISSUE at N+1 and ap_start high after edge N+2.
- sw_abort:
  - In S_ISSUE or S_WAIT_DONE: ap_start drops on the next edge and the FSM enters S_ABORT.
  - S_ABORT waits for ap_idle==1, then goes to S_FINISH. tiles_completed keeps its value.
  - sw_abort is ignored in S_IDLE.
- Counter: tiles_completed never wraps, because it saturates at the tile limit by construction.
- Sticky error flags clear only on reset or on acceptance of a new command.
- Reset mid-layer: everything returns to reset values immediately (asynchronous). ap_start drops without waiting for the controller.

Optional Feature:
- Macro: LAYER_SCHED_WATCHDOG_EN.
- When defined:
  - A cycle counter clears on each entry to S_WAIT_DONE and increments while in that state.
  - When it reaches WDT_CYCLES, err_timeout sets and the FSM goes to S_ABORT, with the same exit path as an abort.
- When undefined: S_WAIT_DONE waits indefinitely, err_timeout is tied to 0, and the counter logic is absent.

Decomposition:
- Shared package:
  - FSM state encoding (localparams S_IDLE..S_ABORT)
  - default widths K_W and TILE_W
  - the WDT_CYCLES default
- Sub-module: sched_watchdog, a clear/enable/expire counter, instantiated only under LAYER_SCHED_WATCHDOG_EN.

Test Plan:
- Normal run: k=32, tiles=3, controller model finishing in 20 cycles -> exactly 3 ap_start rising edges, tiles_completed 1,2,3, a single layer_done pulse, cfg_k_dim=32 throughout.
- Zero tiles: tiles=0, k=32 -> layer_done 2 cycles after accept, no ap_start; a zero-k command (k=0, tiles=4) -> err_zero_k=1, no ap_start.
- Slow acceptance: model holds ap_idle=1 for 5 cycles after ap_start -> ap_start stays high until ap_idle=0, then drops within 1 cycle; no second start before ap_idle returns to 1.
- Busy backpressure: second cmd_valid during the layer -> cmd_ready=0 until the cycle after layer_done, then the second command is accepted with its own k_dim.
- Abort: sw_abort during tile 2 of 4 -> ap_start low, layer_done after ap_idle=1, tiles_completed=1.
- Watchdog (macro on, WDT_CYCLES=100): model never asserts ap_done -> err_timeout=1 at 100 cycles in S_WAIT_DONE, then layer_done; with the macro off, busy stays 1 and err_timeout stays 0.
